ro_pair_counter_ctrl: RTL



---
 rtl/ro_pair_counter_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ro_pair_counter_ctrl.sv
// ro_pair_counter_ctrl
//
// Responder side of the RO PUF challenge handshake. On a measurement request
// it counts rising edges of the two selected ring oscillators over a fixed
// clock window, compares the two counts and registers one signature bit.
//
// Handshake: roen is a level request from the PUF controller. This block
// acknowledges by reading 2'b11 on counter_ctrl_state, and sig_bit/sig_tie
// are valid from the first cycle that reads 2'b11. The acknowledge is held
// for as long as roen stays high. A low roen in any non-IDLE state returns
// the block to IDLE, and a measurement is only started by roen=1 sampled in
// IDLE.
//
// The RO inputs are asynchronous to clk. Each one is passed through a 2-flop
// synchronizer and a previous-value register, so an input transition reaches
// its counter three clk edges later.

module ro_pair_counter_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 roen,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic [1:0]           counter_ctrl_state,
    output logic                 sig_bit,
    output logic                 sig_tie,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    // The timer only has to hold 0..WINDOW-1.
    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [TW-1:0]        TIMER_LAST = TW'(WINDOW - 1);
    localparam logic [TW-1:0]        TIMER_ARM  = TW'(SETTLE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_COMPARE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic          prev_a;
    logic          prev_b;
    logic          edge_a;
    logic          edge_b;
    logic [TW-1:0] timer;

    // Control strobes decoded from the state and the request.
    logic clear_en;
    logic count_en;
    logic compare_en;
    logic timer_last;
    logic count_armed;

    // Bring both RO outputs into the clk domain and keep their prior value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[0], ro_a};
            sync_b <= {sync_b[0], ro_b};
            prev_a <= sync_a[1];
            prev_b <= sync_b[1];
        end
    end

    assign edge_a = sync_a[1] & ~prev_a;
    assign edge_b = sync_b[1] & ~prev_b;

    assign timer_last  = (timer == TIMER_LAST);
    assign count_armed = (timer >= TIMER_ARM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a dropped request always wins over window progress.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (roen) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!roen) begin
                    state_nxt = ST_IDLE;
                end else if (timer_last) begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!roen) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!roen) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: state goes out as-is, strobes steer the datapath.
    always_comb begin
        counter_ctrl_state = state;
        clear_en           = 1'b0;
        count_en           = 1'b0;
        compare_en         = 1'b0;
        case (state)
            ST_IDLE:    clear_en   = roen;
            ST_COUNT:   count_en   = roen;
            ST_COMPARE: compare_en = roen;
            default:    ;
        endcase
    end

    // Window timer: cleared on request, advances each COUNT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (clear_en) begin
            timer <= '0;
        end else if (count_en && !timer_last) begin
            timer <= timer + 1'b1;
        end
    end

    // Edge counters: ignore the settle period and saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (clear_en) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (count_en && count_armed) begin
            if (edge_a && (cnt_a != CNT_MAX)) begin
                cnt_a <= cnt_a + 1'b1;
            end
            if (edge_b && (cnt_b != CNT_MAX)) begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end

    // Signature registers: updated only by a COMPARE cycle that completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_bit <= 1'b0;
            sig_tie <= 1'b0;
        end else if (compare_en) begin
            sig_bit <= (cnt_a > cnt_b);
            sig_tie <= (cnt_a == cnt_b);
        end
    end

endmodule
